// File: rtl/ppu_pkg.sv
// Shared types for the PPU output packer: FSM encoding, packed FIFO word, lane strobes.
// Latency: n/a (types and a combinational helper only).
// Backpressure: n/a.
package ppu_pkg;

    // Width of the address field carried in a buffered word
    localparam int PK_ADDR_W = 16;

    typedef enum logic [1:0] {
        PK_IDLE,
        PK_PACK,
        PK_DRAIN,
        PK_DONE
    } pk_state_t;

    typedef struct packed {
        logic [PK_ADDR_W-1:0] addr;
        logic [31:0]          data;
        logic [3:0]           strb;
    } pk_word_t;

    // Byte-lane enables for a word whose highest filled lane is 'lane'
    function automatic logic [3:0] lane_strb(input logic [1:0] lane);
        logic [3:0] s;
        case (lane)
            2'd0:    s = 4'b0001;
            2'd1:    s = 4'b0011;
            2'd2:    s = 4'b0111;
            default: s = 4'b1111;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/ppu_wb_fifo.sv
// Show-ahead synchronous FIFO of packed output words awaiting GLB write.
// Latency: a pushed word is visible at head the cycle after the push edge.
// Backpressure: push ignored when full unless a pop frees the slot in the same cycle.
module ppu_wb_fifo
    import ppu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  pk_word_t push_dat,
    input  logic     pop,
    output pk_word_t head,
    output logic     full,
    output logic     empty,
    output logic     single
);

    localparam int AW = $clog2(DEPTH);

    pk_word_t    mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] fill;
    logic        do_push;
    logic        do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    assign fill    = wr_ptr - rd_ptr;
    assign empty   = (fill == '0);
    assign full    = (fill == (AW+1)'(DEPTH));
    assign single  = (fill == (AW+1)'(1));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    // Advance read/write pointers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage has no reset: contents are only observed while non-empty
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/ppu_out_packer.sv
// Packs PPU int8 results little-endian into 32-bit words and writes them to GLB with byte strobes.
// Latency: one cycle from the edge capturing a word's last byte to wr_en (empty FIFO).
// Backpressure: wr_ready stalls the FIFO head; input cannot stall, a full FIFO drops the word and sets overflow.
module ppu_out_packer
    import ppu_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_bytes,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              wr_en,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic [3:0]        wr_strb,
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    pk_state_t         state;
    logic [CNT_W-1:0]  byte_cnt;
    logic [CNT_W-1:0]  tile_len;
    logic [ADDR_W-1:0] word_addr;
    logic [31:0]       pack_dat;
    logic [1:0]        lane;
    logic              take;
    logic              last_byte;
    logic              commit;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_single;
    pk_word_t          commit_word;
    pk_word_t          head;

    assign lane      = byte_cnt[1:0];
    assign take      = (state == PK_PACK) && in_valid;
    assign last_byte = ((byte_cnt + CNT_W'(1)) == tile_len);
    assign commit    = take && ((lane == 2'd3) || last_byte);
    assign pop       = !fifo_empty && wr_ready;

    // Word as it would look after merging the incoming byte; lanes above it stay zero
    always_comb begin
        commit_word      = '0;
        commit_word.addr = PK_ADDR_W'(word_addr);
        commit_word.data = pack_dat | ({24'd0, in_data} << {lane, 3'b000});
        commit_word.strb = lane_strb(lane);
    end

    ppu_wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (commit),
        .push_dat (commit_word),
        .pop      (pop),
        .head     (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .single   (fifo_single)
    );

    // Tile FSM, byte counter, pack register, word address and sticky overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= PK_IDLE;
            byte_cnt  <= '0;
            tile_len  <= '0;
            word_addr <= '0;
            pack_dat  <= '0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                PK_IDLE: begin
                    if (start) begin
                        overflow  <= 1'b0;
                        tile_len  <= num_bytes;
                        word_addr <= base_addr;
                        byte_cnt  <= '0;
                        pack_dat  <= '0;
                        state     <= (num_bytes == '0) ? PK_DONE : PK_PACK;
                    end
                end
                PK_PACK: begin
                    if (take) begin
                        byte_cnt <= byte_cnt + CNT_W'(1);
                        if (commit) begin
                            // Address advances even for a dropped word so later words land correctly
                            pack_dat  <= '0;
                            word_addr <= word_addr + ADDR_W'(4);
                            if (fifo_full && !pop) overflow <= 1'b1;
                        end else begin
                            pack_dat <= commit_word.data;
                        end
                        if (last_byte) state <= PK_DRAIN;
                    end
                end
                PK_DRAIN: begin
                    // Leave as the final word transfers so done lands the very next cycle
                    if (fifo_empty || (fifo_single && pop)) state <= PK_DONE;
                end
                PK_DONE: begin
                    state <= PK_IDLE;
                end
                default: begin
                    state <= PK_IDLE;
                end
            endcase
        end
    end

    assign wr_en   = !fifo_empty;
    assign wr_addr = fifo_empty ? '0 : ADDR_W'(head.addr);
    assign wr_data = fifo_empty ? '0 : head.data;
    assign wr_strb = fifo_empty ? '0 : head.strb;
    assign busy    = (state != PK_IDLE);
    assign done    = (state == PK_DONE);

endmodule

// File: tb/tb_ppu_out_packer.sv
module tb_ppu_out_packer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] base_addr;
    logic [15:0] num_bytes;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        wr_en;
    logic        wr_ready;
    logic [15:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        busy;
    logic        done;
    logic        overflow;

    typedef struct packed {
        logic [15:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [31:0] c;
    } wr_rec_t;

    wr_rec_t     wq[$];
    logic [31:0] done_q[$];
    logic [31:0] cyc;
    logic        hold_vld;
    logic [51:0] held;
    int          checks;
    int          errors;

    ppu_out_packer #(
        .ADDR_W     (16),
        .FIFO_DEPTH (4),
        .CNT_W      (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .num_bytes (num_bytes),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .wr_en     (wr_en),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_strb   (wr_strb),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 32'd1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Record transfers and done pulses; a stalled write must reappear unchanged next cycle
    always @(negedge clk) begin
        if (rst) begin
            hold_vld = 1'b0;
        end else begin
            if (hold_vld) chk("hold_stable", {wr_en, wr_addr, wr_data, wr_strb}, {1'b1, held});
            if (wr_en && wr_ready) wq.push_back({wr_addr, wr_data, wr_strb, cyc});
            if (done) done_q.push_back(cyc);
            hold_vld = wr_en && !wr_ready;
            held     = {wr_addr, wr_data, wr_strb};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] b, input logic [15:0] n);
        start     = 1'b1;
        base_addr = b;
        num_bytes = n;
        tick();
        start     = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        tick();
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n;
        n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        chk(tag, {63'd0, busy}, 64'd0);
    endtask

    task automatic chk_wr(input string tag, input int idx, input logic [15:0] a,
                          input logic [31:0] d, input logic [3:0] s);
        if (idx < wq.size())
            chk(tag, {12'd0, wq[idx].a, wq[idx].d, wq[idx].s}, {12'd0, a, d, s});
        else
            chk(tag, 64'(wq.size()), 64'(idx + 1));
    endtask

    function automatic logic [31:0] word_of(input logic [7:0] b0);
        return {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0};
    endfunction

    initial begin
        logic [31:0] c_w0;
        logic [31:0] c_start;
        int          sent;
        int          step;
        int          n;

        checks    = 0;
        errors    = 0;
        cyc       = 0;
        hold_vld  = 1'b0;
        held      = '0;
        rst       = 1'b1;
        start     = 1'b0;
        base_addr = 16'h0000;
        num_bytes = 16'h0000;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        wr_ready  = 1'b1;

        // Reset state
        repeat (3) tick();
        chk("rst_wr_en", {63'd0, wr_en}, 64'd0);
        chk("rst_payload", {12'd0, wr_addr, wr_data, wr_strb}, 64'd0);
        chk("rst_flags", {61'd0, busy, done, overflow}, 64'd0);
        rst = 1'b0;
        tick();

        // 1: two full words, ready always high
        wq.delete();
        done_q.delete();
        do_start(16'h0100, 16'd8);
        chk("t1_busy", {63'd0, busy}, 64'd1);
        for (int i = 1; i <= 8; i++) begin
            send(8'(i));
            if (i == 4) c_w0 = cyc;
        end
        wait_idle(20, "t1_timeout");
        chk("t1_nwr", 64'(wq.size()), 64'd2);
        chk_wr("t1_w0", 0, 16'h0100, 32'h04030201, 4'hF);
        chk_wr("t1_w1", 1, 16'h0104, 32'h08070605, 4'hF);
        if (wq.size() > 0) chk("t1_latency", 64'(wq[0].c), 64'(c_w0));
        chk("t1_ndone", 64'(done_q.size()), 64'd1);
        if (done_q.size() > 0 && wq.size() > 1)
            chk("t1_done_cyc", 64'(done_q[0]), 64'(wq[1].c + 32'd1));

        // 2: partial final word
        wq.delete();
        done_q.delete();
        do_start(16'h0100, 16'd6);
        for (int i = 0; i < 6; i++) send(8'hAA + 8'(i));
        wait_idle(20, "t2_timeout");
        chk("t2_nwr", 64'(wq.size()), 64'd2);
        chk_wr("t2_w0", 0, 16'h0100, 32'hADACABAA, 4'hF);
        chk_wr("t2_w1", 1, 16'h0104, 32'h0000AFAE, 4'b0011);
        if (done_q.size() > 0 && wq.size() > 1)
            chk("t2_done_cyc", 64'(done_q[0]), 64'(wq[1].c + 32'd1));

        // 3: empty tile
        wq.delete();
        done_q.delete();
        do_start(16'h0200, 16'd0);
        c_start = cyc;
        chk("t3_busy_done", {62'd0, busy, done}, 64'd3);
        tick();
        chk("t3_after", {61'd0, busy, done, wr_en}, 64'd0);
        chk("t3_nwr", 64'(wq.size()), 64'd0);
        chk("t3_ndone", 64'(done_q.size()), 64'd1);
        if (done_q.size() > 0) chk("t3_done_cyc", 64'(done_q[0]), 64'(c_start));

        // 4: overflow with the write port stalled
        wq.delete();
        done_q.delete();
        wr_ready = 1'b0;
        do_start(16'h0200, 16'd24);
        for (int i = 0; i < 24; i++) send(8'h10 + 8'(i));
        tick();
        chk("t4_overflow", {63'd0, overflow}, 64'd1);
        chk("t4_head", {11'd0, wr_en, wr_addr, wr_data, wr_strb}, {11'd0, 1'b1, 16'h0200, 32'h13121110, 4'hF});
        chk("t4_busy", {63'd0, busy}, 64'd1);
        wr_ready = 1'b1;
        wait_idle(20, "t4_timeout");
        chk("t4_nwr", 64'(wq.size()), 64'd4);
        for (int k = 0; k < 4; k++)
            chk_wr("t4_w", k, 16'h0200 + 16'(4 * k), word_of(8'h10 + 8'(4 * k)), 4'hF);
        chk("t4_ndone", 64'(done_q.size()), 64'd1);
        chk("t4_ovf_sticky", {63'd0, overflow}, 64'd1);

        // 5: toggled ready, gappy input; start clears overflow
        wq.delete();
        done_q.delete();
        do_start(16'h0300, 16'd16);
        chk("t5_ovf_clear", {63'd0, overflow}, 64'd0);
        sent = 0;
        step = 0;
        while (sent < 16) begin
            wr_ready = ~wr_ready;
            if (step % 3 == 2) begin
                in_valid = 1'b0;
                in_data  = 8'hEE;
            end else begin
                in_valid = 1'b1;
                in_data  = 8'h40 + 8'(sent);
                sent++;
            end
            tick();
            step++;
        end
        in_valid = 1'b0;
        in_data  = 8'h00;
        n = 0;
        while (busy && n < 40) begin
            wr_ready = ~wr_ready;
            tick();
            n++;
        end
        chk("t5_timeout", {63'd0, busy}, 64'd0);
        chk("t5_nwr", 64'(wq.size()), 64'd4);
        for (int k = 0; k < 4; k++)
            chk_wr("t5_w", k, 16'h0300 + 16'(4 * k), word_of(8'h40 + 8'(4 * k)), 4'hF);
        chk("t5_ovf", {63'd0, overflow}, 64'd0);

        // 6: asynchronous reset mid-tile, then a clean tile
        wq.delete();
        done_q.delete();
        wr_ready = 1'b1;
        do_start(16'h0400, 16'd8);
        send(8'h01);
        send(8'h02);
        in_valid = 1'b1;
        in_data  = 8'h03;
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_async", {60'd0, busy, done, overflow, wr_en}, 64'd0);
        chk("t6_rst_payload", {12'd0, wr_addr, wr_data, wr_strb}, 64'd0);
        in_valid = 1'b0;
        in_data  = 8'h00;
        tick();
        tick();
        rst = 1'b0;
        repeat (4) tick();
        chk("t6_no_write", {63'd0, wr_en}, 64'd0);
        chk("t6_nwr_after", 64'(wq.size()), 64'd0);
        do_start(16'h0500, 16'd4);
        for (int i = 0; i < 4; i++) send(8'h55 + 8'(i));
        wait_idle(20, "t6_timeout");
        chk("t6_nwr", 64'(wq.size()), 64'd1);
        chk_wr("t6_w0", 0, 16'h0500, 32'h58575655, 4'hF);
        chk("t6_ndone", 64'(done_q.size()), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
